// File: rtl/mem_stage_issue_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_issue_pkg
// Description : Shared types and constants for the data-memory issue stage:
//               request kind codes, FSM states, bus idle values, and the
//               request-to-bus encoding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_issue_pkg;

  // Request kind codes as presented by the execute stage
  localparam logic [1:0] KIND_ALU  = 2'd0;
  localparam logic [1:0] KIND_LD   = 2'd1;
  localparam logic [1:0] KIND_ST   = 2'd2;
  localparam logic [1:0] KIND_RSVD = 2'd3;

  // Issue-stage controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // One buffered request
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [4:0] rd;
  } req_t;

  // One expectation stage: what the memory block owes us and whether to write it back
  typedef struct packed {
    logic       valid;
    logic       wb;
    logic [4:0] rd;
  } exp_t;

  // Everything driven onto the data-memory ex interface
  typedef struct packed {
    logic       en;
    logic       rw;
    logic       sel;
    logic [7:0] ans;
    logic [7:0] b;
    logic [4:0] tag;
  } bus_t;

  // Bus idle values
  localparam logic       BUS_IDLE_EN  = 1'b0;
  localparam logic       BUS_IDLE_RW  = 1'b0;
  localparam logic       BUS_IDLE_SEL = 1'b1;
  localparam logic [7:0] BUS_IDLE_ANS = 8'h00;
  localparam logic [7:0] BUS_IDLE_B   = 8'h00;
  localparam logic [4:0] BUS_IDLE_TAG = 5'd0;

  localparam bus_t BUS_IDLE = '{en:  BUS_IDLE_EN,  rw: BUS_IDLE_RW, sel: BUS_IDLE_SEL,
                                ans: BUS_IDLE_ANS, b:  BUS_IDLE_B,  tag: BUS_IDLE_TAG};

  // Translate a request into the bus values presented on the cycle it issues
  function automatic bus_t encode_bus(input req_t r);
    bus_t bus;
    bus     = BUS_IDLE;
    bus.ans = r.addr;
    bus.tag = r.rd;
    case (r.kind)
      KIND_LD: begin
        bus.en  = 1'b1;
        bus.rw  = 1'b0;
        bus.sel = 1'b0;
      end
      KIND_ST: begin
        bus.en  = 1'b1;
        bus.rw  = 1'b1;
        bus.sel = 1'b1;
        bus.b   = r.wdata;
      end
      default: begin
        bus.en  = 1'b0;
        bus.rw  = 1'b0;
        bus.sel = 1'b1;
      end
    endcase
    return bus;
  endfunction

  // Stores produce no result and register 0 is hard-wired, so neither writes back
  function automatic logic needs_wb(input req_t r);
    return (r.kind != KIND_ST) && (r.rd != 5'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_issue_req_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : req_fifo
// Description : Synchronous FIFO with power-of-two depth. Head entry is
//               visible on rdata whenever the FIFO is non-empty.
// Revision    : 1.0 - initial release
// ============================================================================
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 23
) (
  input  logic                     clk4,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk4) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk4) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_issue
// Description : Data-memory stage initiator. Buffers execute-stage requests,
//               issues one per cycle on the ex bus, tracks outstanding
//               accesses and forwards returned results to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_issue
  import mem_stage_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic       clk4,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic [4:0] req_rd,
  output logic [7:0] ans_ex,
  output logic [7:0] B_bypass,
  output logic       mem_en_ex,
  output logic       mem_rw_ex,
  output logic       mem_mux_sel_ex,
  output logic [4:0] RW_ex,
  input  logic [7:0] mux_ans_dm,
  input  logic [4:0] RW_dm,
  output logic       wb_valid,
  output logic [7:0] wb_data,
  output logic [4:0] wb_rd,
  output logic       err_tag,
  output logic       err_kind,
  output logic       busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NSTG = MEM_LAT + 1;
  localparam int RW_W = $bits(req_t);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  req_t            in_req;
  req_t            head;
  logic [RW_W-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic            accept;
  logic            push;
  logic            pop;

  exp_t            exp_q [NSTG];
  exp_t            exp_in;
  exp_t            fin;
  logic            in_flight;
  bus_t            bus_q;
  state_t          state_q;
  state_t          state_d;

  assign in_req    = '{kind: req_kind, addr: req_addr, wdata: req_wdata, rd: req_rd};
  assign head      = fifo_rdata;
  assign accept    = req_valid && !fifo_full;
  assign push      = accept && (req_kind != KIND_RSVD);
  assign pop       = !fifo_empty;
  assign req_ready = !fifo_full;
  assign fin       = exp_q[MEM_LAT];
  assign busy      = !fifo_empty || in_flight;

  assign mem_en_ex      = bus_q.en;
  assign mem_rw_ex      = bus_q.rw;
  assign mem_mux_sel_ex = bus_q.sel;
  assign ans_ex         = bus_q.ans;
  assign B_bypass       = bus_q.b;
  assign RW_ex          = bus_q.tag;

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW_W)
  ) u_req_fifo (
    .clk4  (clk4),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_req),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Expectation entering the shift register on the cycle the head issues
  always_comb begin
    exp_in = '0;
    if (pop) begin
      exp_in.valid = 1'b1;
      exp_in.wb    = needs_wb(head);
      exp_in.rd    = head.rd;
    end
  end

  // Expectation shift register; the last stage lines up with the memory's answer
  always_ff @(posedge clk4) begin
    if (rst) begin
      for (int i = 0; i < NSTG; i++) exp_q[i] <= '0;
    end else begin
      exp_q[0] <= exp_in;
      for (int i = 1; i < NSTG; i++) exp_q[i] <= exp_q[i-1];
    end
  end

  // Any outstanding access anywhere in the shift register
  always_comb begin
    in_flight = 1'b0;
    for (int i = 0; i < NSTG; i++) in_flight = in_flight | exp_q[i].valid;
  end

  // Bus register: head values while popping, idle values otherwise
  always_ff @(posedge clk4) begin
    if (rst)      bus_q <= BUS_IDLE;
    else if (pop) bus_q <= encode_bus(head);
    else          bus_q <= BUS_IDLE;
  end

  // Writeback register: forward the returned value for expected, writeable results
  always_ff @(posedge clk4) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= 8'h00;
      wb_rd    <= 5'd0;
    end else if (fin.valid && fin.wb) begin
      wb_valid <= 1'b1;
      wb_data  <= mux_ans_dm;
      wb_rd    <= fin.rd;
    end else begin
      wb_valid <= 1'b0;
      wb_data  <= 8'h00;
      wb_rd    <= 5'd0;
    end
  end

  // Sticky error flags; only reset clears them
  always_ff @(posedge clk4) begin
    if (rst) begin
      err_tag  <= 1'b0;
      err_kind <= 1'b0;
    end else begin
      if (fin.valid && (RW_dm != fin.rd))          err_tag  <= 1'b1;
      if (accept && (req_kind == KIND_RSVD))       err_kind <= 1'b1;
    end
  end

  // Controller state register
  always_ff @(posedge clk4) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Controller next state: issuing while queued, draining while only in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Last queued entry leaves this cycle and nothing replaces it
        if (pop && !push && (fifo_count == CNT_ONE)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (push)           state_d = ST_ISSUE;
        else if (!in_flight) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_issue
// Description : Scoreboard bench for mem_stage_issue with a behavioural
//               data-memory model and a reference model of issue timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_issue;
  import mem_stage_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;
  localparam logic [23:0] IDLE_BUS = {1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'h00};

  logic       clk4 = 1'b0;
  logic       rst  = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_kind  = 2'd0;
  logic [7:0] req_addr  = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic [4:0] req_rd    = 5'd0;
  logic [7:0] ans_ex, B_bypass;
  logic       mem_en_ex, mem_rw_ex, mem_mux_sel_ex;
  logic [4:0] RW_ex;
  logic [7:0] mux_ans_dm;
  logic [4:0] RW_dm;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic [4:0] wb_rd;
  logic       err_tag, err_kind, busy;

  always #5 clk4 = ~clk4;

  mem_stage_issue #(.FIFO_DEPTH(DEPTH), .MEM_LAT(LAT)) dut (
    .clk4(clk4), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .ans_ex(ans_ex), .B_bypass(B_bypass), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex),
    .mem_mux_sel_ex(mem_mux_sel_ex), .RW_ex(RW_ex), .mux_ans_dm(mux_ans_dm), .RW_dm(RW_dm),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .err_tag(err_tag),
    .err_kind(err_kind), .busy(busy)
  );

  int cyc = 0;
  always @(posedge clk4) cyc <= cyc + 1;

  // ---------------- behavioural data memory (environment) ----------------
  logic [7:0] dm [256];
  logic [7:0] pd [LAT];
  logic [4:0] pt [LAT];
  logic       mem_init   = 1'b0;
  logic       flip_all   = 1'b0;
  logic [4:0] corrupt_rd = 5'd0;

  assign mux_ans_dm = pd[LAT-1];
  assign RW_dm      = pt[LAT-1] ^ {4'b0000, flip_all};

  always @(posedge clk4) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) dm[i] <= 8'(i) ^ 8'h5A;
      for (int i = 0; i < LAT; i++) begin pd[i] <= 8'h00; pt[i] <= 5'd0; end
      mem_init <= 1'b1;
    end else begin
      if (mem_en_ex && mem_rw_ex) dm[ans_ex] <= B_bypass;
      pd[0] <= mem_mux_sel_ex ? ans_ex : dm[ans_ex];
      pt[0] <= RW_ex ^ (((corrupt_rd != 5'd0) && (RW_ex == corrupt_rd)) ? 5'd1 : 5'd0);
      for (int i = 1; i < LAT; i++) begin pd[i] <= pd[i-1]; pt[i] <= pt[i-1]; end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct { int due; logic [4:0] rd; logic [7:0] data; } wb_exp_t;
  typedef struct { int acc; int issue; logic [23:0] bus; logic [23:0] mask; } bus_exp_t;

  wb_exp_t  sb[$];
  bus_exp_t bq[$];
  logic [7:0] ref_mem [256];
  int last_issue = 0;
  int busy_start = 0;
  int busy_until = 0;
  int tests = 0;
  int fails = 0;
  int wb_seen = 0;
  bit mon_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record what an accepted request must produce: issue slot, bus values, result
  task automatic model_accept(input logic [1:0] k, input logic [7:0] a, input logic [7:0] w,
                              input logic [4:0] r);
    int acc, iss, due;
    bus_exp_t be;
    wb_exp_t  we;
    acc = cyc + 1;
    if (k == 2'd3) return;
    iss = (acc + 1 > last_issue + 1) ? acc + 1 : last_issue + 1;
    last_issue = iss;
    due = iss + 1 + LAT;
    be.acc   = acc;
    be.issue = iss;
    be.bus   = {k != 2'd0, k == 2'd2, k != 2'd1, a, (k == 2'd2) ? w : 8'h00, r};
    be.mask  = {3'b111, 8'hFF, (k == 2'd2) ? 8'hFF : 8'h00, 5'h1F};
    bq.push_back(be);
    if (acc > busy_until) busy_start = acc;
    if (due > busy_until) busy_until = due;
    if (k == 2'd2) begin
      ref_mem[a] = w;
    end else if (r != 5'd0) begin
      we.due  = due;
      we.rd   = r;
      we.data = (k == 2'd1) ? ref_mem[a] : a;
      sb.push_back(we);
    end
  endtask

  // Monitor: bus, ready, busy and writeback checked every cycle against the model
  always @(negedge clk4) begin
    if (mon_on) begin : mon_blk
      logic [23:0] act, expv, m;
      int occ;
      wb_exp_t e;
      act = {mem_en_ex, mem_rw_ex, mem_mux_sel_ex, ans_ex, B_bypass, RW_ex};
      occ = 0;
      foreach (bq[i]) if (bq[i].acc <= cyc && bq[i].issue > cyc) occ++;
      check("req_ready", 32'(req_ready), 32'(occ < DEPTH));
      if (bq.size() > 0 && bq[0].issue == cyc) begin
        expv = bq[0].bus;
        m    = bq[0].mask;
        void'(bq.pop_front());
      end else begin
        expv = IDLE_BUS;
        m    = '1;
      end
      check("bus", 32'(act & m), 32'(expv));
      check("busy", 32'(busy), 32'(cyc >= busy_start && cyc < busy_until));
      if (wb_valid) begin
        if (sb.size() == 0) begin
          check("wb_valid_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          wb_seen++;
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_data", 32'(wb_data), 32'(e.data));
          check("wb_cycle", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("wb_valid_missing", 32'(wb_valid), 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // Offer one request, holding it until accepted (bounded)
  task automatic send(input logic [1:0] k, input logic [7:0] a, input logic [7:0] w,
                      input logic [4:0] r);
    int waited;
    waited    = 0;
    req_valid = 1'b1;
    req_kind  = k;
    req_addr  = a;
    req_wdata = w;
    req_rd    = r;
    while (!req_ready && waited < 50) begin
      @(negedge clk4);
      waited++;
    end
    if (!req_ready) check("send_timeout", 32'(req_ready), 32'd1);
    else            model_accept(k, a, w, r);
    @(negedge clk4);
    req_valid = 1'b0;
  endtask

  // Wait for every modelled result and issue slot to retire (bounded)
  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bq.size() != 0 || cyc < busy_until) && n < 200) begin
      @(negedge clk4);
      n++;
    end
    check("drain_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int wb0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk4);
    check("rst_bus", 32'({mem_en_ex, mem_rw_ex, mem_mux_sel_ex, ans_ex, B_bypass, RW_ex}), 32'(IDLE_BUS));
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wb", 32'({wb_valid, wb_data, wb_rd}), 32'd0);
    check("rst_err", 32'({err_tag, err_kind}), 32'd0);
    rst = 1'b0;
    last_issue = cyc;
    mon_on = 1'b1;
    repeat (3) @(negedge clk4);

    // Store then load to the same address
    wb0 = wb_seen;
    send(2'd2, 8'h05, 8'h0A, 5'd8);
    send(2'd1, 8'h05, 8'h00, 5'd9);
    drain();
    check("st_ld_wb_count", wb_seen - wb0, 1);

    // ALU pass-through, then the rd 0 variant
    wb0 = wb_seen;
    send(2'd0, 8'h14, 8'h00, 5'd3);
    send(2'd0, 8'h14, 8'h00, 5'd0);
    drain();
    check("alu_wb_count", wb_seen - wb0, 1);

    // Six back-to-back mixed requests
    wb0 = wb_seen;
    for (int i = 0; i < 6; i++) send(2'(i % 3), 8'h20 + 8'(i), 8'h40 + 8'(i), 5'd10 + 5'(i));
    drain();
    check("b2b_wb_count", wb_seen - wb0, 4);
    repeat (2) @(negedge clk4);
    check("fsm_idle_after_drain", 32'(dut.state_q), 32'(ST_IDLE));

    // Corrupted returned tag sets a sticky error
    check("err_tag_clean", 32'(err_tag), 32'd0);
    corrupt_rd = 5'd17;
    send(2'd0, 8'h33, 8'h00, 5'd17);
    drain();
    corrupt_rd = 5'd0;
    check("err_tag_set", 32'(err_tag), 32'd1);
    repeat (5) @(negedge clk4);
    check("err_tag_sticky", 32'(err_tag), 32'd1);

    // Reserved kind: dropped, sticky error, no issue
    check("err_kind_clean", 32'(err_kind), 32'd0);
    send(2'd3, 8'h44, 8'h55, 5'd12);
    drain();
    check("err_kind_set", 32'(err_kind), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [1:0] k;
      repeat ($urandom_range(0, 2)) @(negedge clk4);
      k = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      send(k, 8'($urandom_range(0, 15)), 8'($urandom), 5'($urandom_range(0, 31)));
    end
    drain();
    check("err_kind_still_set", 32'(err_kind), 32'd1);

    // Reset with accesses queued and in flight
    send(2'd0, 8'h61, 8'h00, 5'd4);
    send(2'd1, 8'h02, 8'h00, 5'd5);
    send(2'd0, 8'h63, 8'h00, 5'd6);
    send(2'd1, 8'h03, 8'h00, 5'd7);
    rst = 1'b1;
    mon_on = 1'b0;
    @(negedge clk4);
    check("midrst_bus", 32'({mem_en_ex, mem_rw_ex, mem_mux_sel_ex, ans_ex, B_bypass, RW_ex}), 32'(IDLE_BUS));
    check("midrst_wb_valid", 32'(wb_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'({err_tag, err_kind}), 32'd0);
    check("midrst_fsm", 32'(dut.state_q), 32'(ST_IDLE));
    sb.delete();
    bq.delete();
    busy_start = 0;
    busy_until = 0;
    last_issue = cyc;
    rst = 1'b0;
    flip_all = 1'b1;
    mon_on = 1'b1;
    repeat (8) @(negedge clk4);
    flip_all = 1'b0;
    check("postrst_err_tag", 32'(err_tag), 32'd0);
    check("postrst_fsm", 32'(dut.state_q), 32'(ST_IDLE));

    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
